acc_unit: RTL and testbench
===========================

# acc_unit

Parametrised successor to the 8-bit SAP accumulator. A WIDTH-bit accumulator register with an operation port (load, add, subtract, shift, clear, and an optional iterative multiply), an N/Z/C/V flag register and a valid/ready handshake. It sits between the datapath bus and the ALU: `s` always feeds the ALU, and `bus` drives the shared bus when `ea` is high.

## Interface
- `WIDTH`, 8: accumulator, operand and bus width (≥ 2).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `clr`  in  1: synchronous, active-high reset.
- `op_valid`  in  1: operation request.
- `op`  in  3: opcode; 0 NOP, 1 LOAD, 2 ADD, 3 SUB, 4 SHL, 5 SHR, 6 CLR, 7 MUL.
- `operand`  in  WIDTH: operand, sampled at accept.
- `op_ready`  out  1: block can accept an operation.
- `done`  out  1: one-cycle pulse when the result of an accepted op is visible.
- `busy`  out  1: multiply in progress.
- `ea`  in  1: bus output enable.
- `bus`  out  WIDTH: accumulator value when `ea`=1, otherwise all zeros (combinational).
- `s`  out  WIDTH: accumulator value, always driven.
- `flags`  out  4: {N, Z, C, V}.

## Operation
- An op is accepted on a rising edge where `op_valid && op_ready`. `op_valid` is ignored while `op_ready`=0.
- Reset values: acc=0, flags=4'b0100 (Z=1), `done`=0, `busy`=0, `op_ready`=1, FSM in IDLE.
- Single-cycle ops write acc and flags on the accept edge:
  - LOAD: acc=operand; C=V=0.
  - ADD: acc=acc+operand mod 2^WIDTH; C=carry out; V=signed overflow.
  - SUB: acc=acc−operand mod 2^WIDTH; C=borrow (acc<operand unsigned); V=signed overflow.
  - SHL: acc<<1, zero-fill; C=old msb; V=0.
  - SHR: logical >>1; C=old lsb; V=0.
  - CLR: acc=0; C=V=0.
  - NOP: acc and flags unchanged; `done` still pulses.
- N=msb of result and Z=(result==0) on every op that writes acc.
- FSM states:
  - IDLE: `op_ready`=1. An accepted MUL goes to MULT; every other op stays in IDLE.
  - MULT: `busy`=1, `op_ready`=0. Shift-add over WIDTH cycles, with multiplicand=acc and multiplier=operand captured at accept, into a 2·WIDTH product.
  - On the final cycle of MULT: acc=product[WIDTH-1:0]; C=|product[2·WIDTH-1:WIDTH]; V=0; N/Z from the low half; return to IDLE.
- acc and `s` hold their pre-multiply value throughout MULT.
- `clr` has priority over everything. Asserting it mid-multiply aborts with no `done` pulse and restores the reset values on that edge.

## Timing
- Single-cycle op accepted at edge k: result on `s`/`flags` after edge k; `done`=1 for the cycle after edge k; `op_ready` stays 1, so back-to-back ops every cycle are allowed.
- MUL accepted at edge k:
  - `busy`=1 and `op_ready`=0 after edges k … k+WIDTH−1.
  - Result, `done`=1, `busy`=0 and `op_ready`=1 after edge k+WIDTH.
  - A new op may be accepted at edge k+WIDTH+1.
- `bus` and `s` are combinational from the acc register; zero added latency.

## Configuration
- `ACC_UNIT_MUL_EN` defined: MUL (op 7) runs as described, and the MULT state and multiplier are built.
- Not defined:
  - op 7 behaves as NOP: accepted in one cycle, `done` pulses, acc and flags unchanged.
  - `busy` is tied to 0 and no multiplier logic is synthesised.

## Structure
- Package `acc_pkg`:
  - op enum (NOP…MUL, 3 bits);
  - flag index constants (FLAG_V=0, FLAG_C=1, FLAG_Z=2, FLAG_N=3);
  - FSM state enum (IDLE, MULT).
- Sub-module `acc_mul_seq` (WIDTH-parameterised shift-add core with start/count/product), instantiated only under `ACC_UNIT_MUL_EN`.
- Flag and ALU logic stay in `acc_unit`.

## Test plan
All scenarios use WIDTH=8.
- Reset: `clr`=1 for one edge → `s`=0x00, `bus`=0x00, `flags`=4'b0100, `op_ready`=1, `done`=0, `busy`=0.
- LOAD 0x7F then ADD 0x01 on consecutive edges:
  - `done` pulses both cycles; `s`=0x80, N=1, Z=0, C=0, V=1.
  - `ea`=0 → `bus`=0x00; `ea`=1 → `bus`=0x80.
- LOAD 0x05, SUB 0x05 → `s`=0x00, Z=1, C=0. Then SUB 0x01 → `s`=0xFF, N=1, C=1, V=0.
- LOAD 0x81, SHL → `s`=0x02, C=1. Then SHR → `s`=0x01, C=0, V=0.
- Macro on: LOAD 0x0C, then MUL 0x0B with `op_valid` held high (ADD 0x01) during MULT:
  - `op_ready`=0 for 8 cycles; ADD not accepted while busy.
  - `done` after edge k+8; `s`=0x84, C=0.
  - LOAD 0x20, MUL 0x10 → `s`=0x00, Z=1, C=1.
- Macro on: `clr`=1 at third MULT cycle → no `done`, `s`=0x00, `op_ready`=1, `busy`=0 next cycle. Macro off: LOAD 0x33, MUL 0x02 → `done` next cycle, `s`=0x33, flags unchanged.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared types for the accumulator unit: opcodes, flag bit positions and FSM states.
package acc_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_SHL  = 3'd4,
        OP_SHR  = 3'd5,
        OP_CLR  = 3'd6,
        OP_MUL  = 3'd7
    } acc_op_e;

    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

    typedef enum logic {
        IDLE = 1'b0,
        MULT = 1'b1
    } acc_state_e;

    function automatic logic [3:0] mk_flags(input logic n, input logic z,
                                            input logic c, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/acc_mul_seq.sv
// Iterative shift-add multiplier core; one partial product per step, WIDTH steps total.
// product_o already includes the current step, so the owner can commit it on the last cycle.
module acc_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start_i,
    input  logic               step_i,
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic               last_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      count_q, count_d;

    assign product_o = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign last_o    = (count_q == CW'(WIDTH - 1));

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        count_d  = count_q;
        if (start_i) begin
            mcand_d  = {{WIDTH{1'b0}}, mcand_i};
            mplier_d = mplier_i;
            prod_d   = '0;
            count_d  = '0;
        end else if (step_i && !last_o) begin
            prod_d   = product_o;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            count_q  <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/acc_unit.sv
// WIDTH-bit accumulator with N/Z/C/V flags and a valid/ready op port.
// Optional iterative multiply is built only when ACC_UNIT_MUL_EN is defined.
module acc_unit
    import acc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    output logic             op_ready,
    output logic             done,
    output logic             busy,
    input  logic             ea,
    output logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] s,
    output logic [3:0]       flags,
    output acc_state_e       state_o
);

    // Handshake: an op is taken on a rising edge with op_valid && op_ready;
    // op_valid is ignored while op_ready is low, and done pulses once per result.

    acc_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d;

    acc_op_e          op_e;
    logic [WIDTH:0]   add_w, sub_w;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_wr;
    logic             accept, start_mul;

    assign op_e     = acc_op_e'(op);
    assign op_ready = (state_q == IDLE);
    assign accept   = op_valid && op_ready;
    assign done     = done_q;
    assign s        = acc_q;
    assign bus      = ea ? acc_q : '0;
    assign flags    = flags_q;
    assign state_o  = state_q;

    assign add_w = {1'b0, acc_q} + {1'b0, operand};
    assign sub_w = {1'b0, acc_q} - {1'b0, operand};

    always_comb begin
        alu_res = acc_q;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_wr  = 1'b0;
        case (op_e)
            OP_LOAD: begin
                alu_res = operand;
                alu_wr  = 1'b1;
            end
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (acc_q[WIDTH-1] == operand[WIDTH-1]) &&
                          (add_w[WIDTH-1] != acc_q[WIDTH-1]);
                alu_wr  = 1'b1;
            end
            OP_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
                alu_v   = (acc_q[WIDTH-1] != operand[WIDTH-1]) &&
                          (sub_w[WIDTH-1] != acc_q[WIDTH-1]);
                alu_wr  = 1'b1;
            end
            OP_SHL: begin
                alu_res = {acc_q[WIDTH-2:0], 1'b0};
                alu_c   = acc_q[WIDTH-1];
                alu_wr  = 1'b1;
            end
            OP_SHR: begin
                alu_res = {1'b0, acc_q[WIDTH-1:1]};
                alu_c   = acc_q[0];
                alu_wr  = 1'b1;
            end
            OP_CLR: begin
                alu_res = '0;
                alu_wr  = 1'b1;
            end
            default: begin
                alu_wr  = 1'b0;
            end
        endcase
    end

`ifdef ACC_UNIT_MUL_EN
    logic               mul_last;
    logic [2*WIDTH-1:0] mul_product;

    assign start_mul = accept && (op_e == OP_MUL);
    assign busy      = (state_q == MULT);

    acc_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk      (clk),
        .clr      (clr),
        .start_i  (start_mul),
        .step_i   (state_q == MULT),
        .mcand_i  (acc_q),
        .mplier_i (operand),
        .last_o   (mul_last),
        .product_o(mul_product)
    );
`else
    assign start_mul = 1'b0;
    assign busy      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        flags_d = flags_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_mul) begin
                    state_d = MULT;
                end else if (accept) begin
                    done_d = 1'b1;
                    if (alu_wr) begin
                        acc_d   = alu_res;
                        flags_d = mk_flags(alu_res[WIDTH-1], alu_res == '0, alu_c, alu_v);
                    end
                end
            end
`ifdef ACC_UNIT_MUL_EN
            MULT: begin
                if (mul_last) begin
                    acc_d   = mul_product[WIDTH-1:0];
                    flags_d = mk_flags(mul_product[WIDTH-1], mul_product[WIDTH-1:0] == '0,
                                       |mul_product[2*WIDTH-1:WIDTH], 1'b0);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            acc_q   <= '0;
            flags_q <= 4'b0100;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_acc_unit.sv
// Self-checking bench for acc_unit (WIDTH=8): vector table for single-cycle ops,
// hand-written sequences for multiply and abort; multiply cases need ACC_UNIT_MUL_EN.
module tb_acc_unit;
    import acc_pkg::*;

    logic       clk;
    logic       clr;
    logic       op_valid;
    logic [2:0] op;
    logic [7:0] operand;
    logic       op_ready;
    logic       done;
    logic       busy;
    logic       ea;
    logic [7:0] bus;
    logic [7:0] s;
    logic [3:0] flags;
    acc_state_e dbg_state;

    int checks;
    int failures;

    acc_unit #(.WIDTH(8)) dut (
        .clk     (clk),
        .clr     (clr),
        .op_valid(op_valid),
        .op      (op),
        .operand (operand),
        .op_ready(op_ready),
        .done    (done),
        .busy    (busy),
        .ea      (ea),
        .bus     (bus),
        .s       (s),
        .flags   (flags),
        .state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [2:0] op;
        logic [7:0] opd;
        logic       ea;
        logic [7:0] s;
        logic [3:0] fl;
        logic       dn;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [2:0] o, input logic [7:0] d);
        op_valid = vld;
        op       = o;
        operand  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        drive(1'b0, 3'd0, 8'h00);
        tick();
        clr = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        ea       = 1'b0;
        clr      = 1'b0;
        drive(1'b0, 3'd0, 8'h00);

        //            vld   op    opd    ea    s      flags NZCV  done
        vecs[0]  = '{1'b1, 3'd1, 8'h7F, 1'b0, 8'h7F, 4'b0000, 1'b1};
        vecs[1]  = '{1'b1, 3'd2, 8'h01, 1'b1, 8'h80, 4'b1001, 1'b1};
        vecs[2]  = '{1'b1, 3'd1, 8'h05, 1'b0, 8'h05, 4'b0000, 1'b1};
        vecs[3]  = '{1'b1, 3'd3, 8'h05, 1'b1, 8'h00, 4'b0100, 1'b1};
        vecs[4]  = '{1'b1, 3'd3, 8'h01, 1'b1, 8'hFF, 4'b1010, 1'b1};
        vecs[5]  = '{1'b1, 3'd1, 8'h81, 1'b0, 8'h81, 4'b1000, 1'b1};
        vecs[6]  = '{1'b1, 3'd4, 8'h00, 1'b1, 8'h02, 4'b0010, 1'b1};
        vecs[7]  = '{1'b1, 3'd5, 8'h00, 1'b0, 8'h01, 4'b0000, 1'b1};
        vecs[8]  = '{1'b1, 3'd0, 8'h55, 1'b1, 8'h01, 4'b0000, 1'b1};
        vecs[9]  = '{1'b1, 3'd2, 8'hFF, 1'b0, 8'h00, 4'b0110, 1'b1};
        vecs[10] = '{1'b1, 3'd6, 8'h99, 1'b1, 8'h00, 4'b0100, 1'b1};
        vecs[11] = '{1'b1, 3'd3, 8'h80, 1'b1, 8'h80, 4'b1011, 1'b1};
        vecs[12] = '{1'b1, 3'd5, 8'h00, 1'b1, 8'h40, 4'b0000, 1'b1};
        vecs[13] = '{1'b0, 3'd2, 8'h01, 1'b1, 8'h40, 4'b0000, 1'b0};

        // reset
        do_reset();
        chk("rst_s", 32'(s), 32'h00);
        chk("rst_bus", 32'(bus), 32'h00);
        chk("rst_flags", 32'(flags), 32'b0100);
        chk("rst_ready", 32'(op_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // table-driven single-cycle ops, back to back
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].vld, vecs[i].op, vecs[i].opd);
            ea = vecs[i].ea;
            tick();
            chk($sformatf("v%0d_s", i), 32'(s), 32'(vecs[i].s));
            chk($sformatf("v%0d_flags", i), 32'(flags), 32'(vecs[i].fl));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].dn));
            chk($sformatf("v%0d_ready", i), 32'(op_ready), 32'd1);
            chk($sformatf("v%0d_bus", i), 32'(bus), vecs[i].ea ? 32'(vecs[i].s) : 32'h0);
        end
        drive(1'b0, 3'd0, 8'h00);
        ea = 1'b0;
        tick();

`ifdef ACC_UNIT_MUL_EN
        // MUL 0x0C * 0x0B with ADD held on op_valid during MULT
        drive(1'b1, 3'd1, 8'h0C);
        tick();
        drive(1'b1, 3'd7, 8'h0B);
        tick();
        drive(1'b1, 3'd2, 8'h01);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("m1_busy%0d", i), 32'(busy), 32'd1);
            chk($sformatf("m1_ready%0d", i), 32'(op_ready), 32'd0);
            chk($sformatf("m1_done%0d", i), 32'(done), 32'd0);
            chk($sformatf("m1_hold%0d", i), 32'(s), 32'h0C);
            chk($sformatf("m1_state%0d", i), 32'(dbg_state), 32'(MULT));
            if (i < 7) tick();
        end
        tick();
        chk("m1_s", 32'(s), 32'h84);
        chk("m1_flags", 32'(flags), 32'b1000);
        chk("m1_done", 32'(done), 32'd1);
        chk("m1_busy_end", 32'(busy), 32'd0);
        chk("m1_ready_end", 32'(op_ready), 32'd1);
        drive(1'b0, 3'd0, 8'h00);
        tick();
        chk("m1_no_add", 32'(s), 32'h84);
        chk("m1_done_low", 32'(done), 32'd0);

        // MUL 0x20 * 0x10 overflows entirely into the high half
        drive(1'b1, 3'd1, 8'h20);
        tick();
        drive(1'b1, 3'd7, 8'h10);
        tick();
        drive(1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 8; i++) tick();
        chk("m2_s", 32'(s), 32'h00);
        chk("m2_flags", 32'(flags), 32'b0110);
        chk("m2_done", 32'(done), 32'd1);

        // clr during the third MULT cycle aborts
        drive(1'b1, 3'd1, 8'h07);
        tick();
        drive(1'b1, 3'd7, 8'h03);
        tick();
        drive(1'b0, 3'd0, 8'h00);
        tick();
        tick();
        chk("ab_busy_pre", 32'(busy), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ab_s", 32'(s), 32'h00);
        chk("ab_flags", 32'(flags), 32'b0100);
        chk("ab_ready", 32'(op_ready), 32'd1);
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_done", 32'(done), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("ab_nodone%0d", i), 32'(done), 32'd0);
        end
        chk("ab_s_hold", 32'(s), 32'h00);
`else
        // op 7 degrades to NOP when multiply is not built
        drive(1'b1, 3'd1, 8'h33);
        tick();
        chk("nm_load_s", 32'(s), 32'h33);
        drive(1'b1, 3'd7, 8'h02);
        tick();
        chk("nm_done", 32'(done), 32'd1);
        chk("nm_s", 32'(s), 32'h33);
        chk("nm_flags", 32'(flags), 32'b0000);
        chk("nm_busy", 32'(busy), 32'd0);
        chk("nm_ready", 32'(op_ready), 32'd1);
        drive(1'b0, 3'd0, 8'h00);
        tick();
        chk("nm_done_low", 32'(done), 32'd0);
`endif

        // clr on an idle edge restores reset values
        drive(1'b1, 3'd1, 8'hA5);
        tick();
        chk("pre_clr_s", 32'(s), 32'hA5);
        do_reset();
        chk("clr2_s", 32'(s), 32'h00);
        chk("clr2_flags", 32'(flags), 32'b0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
